// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined add/subtract unit. The WIDTH-bit carry chain is split into
//   STAGES chunks of C = WIDTH/STAGES bits, one chunk per register stage.
//   The unused upper operand chunks and the op code travel with their beat.
//   Supports add, subtract, reverse subtract and add with carry-in. SAT=1
//   clamps results that carry or borrow.
//
// Ports
//   clk        clock; all state updates on posedge
//   rst        asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   a, b       unsigned operands, WIDTH bits
//   op         00 a+b, 01 a-b, 10 b-a, 11 a+b+1
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   y          WIDTH+1 bit result; y[WIDTH] is carry (add) or borrow (sub)
//   sat        result was clamped (always 0 when SAT=0)
//
// Handshake: a beat moves across an interface on a posedge where valid and
// ready are both high. The pipeline stalls only when the output holds a
// beat that is not being taken (stall = out_valid & ~out_ready). While
// stalled, every register holds. Otherwise every stage advances, and empty
// slots advance like data. in_ready = ~stall, so it follows out_ready
// combinationally.

module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic             sat
);

  localparam int C = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > 4) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_addsub: STAGES must be 1..4 and divide WIDTH");
  end

  // Per-stage registers. Element k is the output of stage k. x_q and z_q
  // hold the operand chunks that are not yet consumed, right-aligned.
  // r_q accumulates result chunks from the top down. In the last stage,
  // r_q and c_q hold the final y.
  logic [WIDTH-1:0] x_q  [STAGES];
  logic [WIDTH-1:0] z_q  [STAGES];
  logic [WIDTH-1:0] r_q  [STAGES];
  logic             c_q  [STAGES];
  logic             v_q  [STAGES];
  logic [1:0]       op_q [STAGES];

  logic             stall;
  logic [WIDTH-1:0] x0, z0;
  logic             cin0;
  logic             sat_d, sat_q;

  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign y         = {c_q[STAGES-1], r_q[STAGES-1]};
  assign sat       = sat_q;

  // Subtraction is done as x + ~z + 1. For rsub the operands swap roles.
  always_comb begin
    x0   = a;
    z0   = b;
    cin0 = 1'b0;
    case (op)
      2'b01:   begin x0 = a; z0 = ~b; cin0 = 1'b1; end
      2'b10:   begin x0 = b; z0 = ~a; cin0 = 1'b1; end
      2'b11:   begin x0 = a; z0 = b;  cin0 = 1'b1; end
      default: begin x0 = a; z0 = b;  cin0 = 1'b0; end
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] cx, cz, cr, res, nr;
    logic             cc, cv, nc;
    logic [1:0]       cop;
    logic [C:0]       sum;

    if (k == 0) begin : g_in
      assign cx  = x0;
      assign cz  = z0;
      assign cr  = '0;
      assign cc  = cin0;
      assign cv  = in_valid;
      assign cop = op;
    end else begin : g_link
      assign cx  = x_q[k-1];
      assign cz  = z_q[k-1];
      assign cr  = r_q[k-1];
      assign cc  = c_q[k-1];
      assign cv  = v_q[k-1];
      assign cop = op_q[k-1];
    end

    assign sum = {1'b0, cx[C-1:0]} + {1'b0, cz[C-1:0]} + {{C{1'b0}}, cc};

    // The new chunk enters at the top and earlier chunks shift down. After
    // STAGES stages, chunk 0 sits at bit 0.
    assign res = (cr >> C) | (WIDTH'(sum[C-1:0]) << (WIDTH - C));

    if (k == STAGES - 1) begin : g_last
      logic is_sub, hi, clamp;
      // Carry out of a subtraction means no borrow.
      assign is_sub = cop[0] ^ cop[1];
      assign hi     = is_sub ? ~sum[C] : sum[C];
      assign clamp  = (SAT != 0) && hi;
      assign nc     = hi;
      assign nr     = clamp ? (is_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : res;
      assign sat_d  = clamp;
    end else begin : g_mid
      assign nc = sum[C];
      assign nr = res;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q[k]  <= 1'b0;
        op_q[k] <= '0;
        x_q[k]  <= '0;
        z_q[k]  <= '0;
        r_q[k]  <= '0;
        c_q[k]  <= 1'b0;
      end else if (!stall) begin
        v_q[k]  <= cv;
        op_q[k] <= cop;
        x_q[k]  <= cx >> C;
        z_q[k]  <= cz >> C;
        r_q[k]  <= nr;
        c_q[k]  <= nc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (!stall) begin
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
//   Directed bench for pipelined_addsub. It uses three instances:
//     dut   WIDTH=8, STAGES=2, SAT=0
//     dut_s WIDTH=8, STAGES=2, SAT=1, driven with the same inputs as dut
//     dut4  WIDTH=4, STAGES=1, SAT=0, the legacy-adder regression
//   Inputs are driven on the falling edge. Outputs are sampled on the
//   falling edge, or 1 time unit after it.

module tb_pipelined_addsub;

  logic       clk;
  logic       rst;
  logic       in_valid, out_ready;
  logic       in_ready, in_ready_s;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       out_valid, out_valid_s;
  logic [8:0] y, y_s;
  logic       sat, sat_s;

  logic       in_valid4, out_ready4, in_ready4, out_valid4, sat4;
  logic [3:0] a4, b4;
  logic [1:0] op4;
  logic [4:0] y4;

  int checks = 0;
  int errors = 0;

  pipelined_addsub #(.WIDTH(8), .STAGES(2), .SAT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .sat(sat)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(2), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
    .y(y_s), .sat(sat_s)
  );

  pipelined_addsub #(.WIDTH(4), .STAGES(1), .SAT(0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
    .y(y4), .sat(sat4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1);
  end

  // Driver: sends one beat to dut/dut_s on an empty pipeline. It then waits,
  // within a bound, for the result and reports the result and the latency
  // in cycles.
  task automatic run_beat(input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] xop,
                          output logic [8:0] ry, output logic rs,
                          output logic [8:0] rys, output logic rss, output int lat);
    @(negedge clk);
    a = xa; b = xb; op = xop; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    ry = y; rs = sat; rys = y_s; rss = sat_s;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || y !== 9'h000 || sat !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b y=%h sat=%b in_ready=%b required 0 000 0 1",
               out_valid, y, sat, in_ready);
    end
    checks++;
    if (out_valid_s !== 1'b0 || y_s !== 9'h000 || sat_s !== 1'b0 || out_valid4 !== 1'b0 || y4 !== 5'h00) begin
      errors++;
      $display("FAIL reset_state_others: ov_s=%b y_s=%h sat_s=%b ov4=%b y4=%h required all 0",
               out_valid_s, y_s, sat_s, out_valid4, y4);
    end
    rst = 1'b1;
    // Three beats in flight, then reset asserted between edges.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'(16 * i); b = 8'(i); op = 2'b00;
    end
    checks++;
    if (out_valid !== 1'b1 || y !== 9'h011) begin
      errors++;
      $display("FAIL reset_prefill: out_valid=%b y=%h required 1 011", out_valid, y);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 9'h000 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b y=%h sat=%b required 0 000 0", out_valid, y, sat);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_stale: cycle %0d out_valid=%b y=%h required out_valid 0", i, out_valid, y);
      end
    end
  endtask

  task automatic test_carry_chain;
    logic [8:0] ry, rys;
    logic rs, rss;
    int lat;
    run_beat(8'hC8, 8'h64, 2'b00, ry, rs, rys, rss, lat);
    checks++;
    if (lat !== 2 || ry !== 9'h12C || rs !== 1'b0) begin
      errors++;
      $display("FAIL add_chunk_carry: lat=%0d y=%h sat=%b required 2 12c 0", lat, ry, rs);
    end
    checks++;
    if (rys !== 9'h1FF || rss !== 1'b1) begin
      errors++;
      $display("FAIL add_chunk_carry_sat: y=%h sat=%b required 1ff 1", rys, rss);
    end
    run_beat(8'hFF, 8'h01, 2'b00, ry, rs, rys, rss, lat);
    checks++;
    if (lat !== 2 || ry !== 9'h100 || rs !== 1'b0) begin
      errors++;
      $display("FAIL add_ff_01: lat=%0d y=%h sat=%b required 2 100 0", lat, ry, rs);
    end
    run_beat(8'h12, 8'h34, 2'b00, ry, rs, rys, rss, lat);
    checks++;
    if (ry !== 9'h046 || rys !== 9'h046 || rss !== 1'b0) begin
      errors++;
      $display("FAIL add_plain: y=%h y_sat=%h sat_sat=%b required 046 046 0", ry, rys, rss);
    end
  endtask

  task automatic test_subtract;
    logic [8:0] ry, rys;
    logic rs, rss;
    int lat;
    run_beat(8'd5, 8'd7, 2'b01, ry, rs, rys, rss, lat);
    checks++;
    if (ry !== 9'h1FE || rs !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: y=%h sat=%b required 1fe 0", ry, rs);
    end
    checks++;
    if (rys !== 9'h100 || rss !== 1'b1) begin
      errors++;
      $display("FAIL sub_sat: y=%h sat=%b required 100 1", rys, rss);
    end
    run_beat(8'd5, 8'd7, 2'b10, ry, rs, rys, rss, lat);
    checks++;
    if (ry !== 9'h002 || rys !== 9'h002 || rss !== 1'b0) begin
      errors++;
      $display("FAIL rsub: y=%h y_sat=%h sat_sat=%b required 002 002 0", ry, rys, rss);
    end
    run_beat(8'h30, 8'hA0, 2'b10, ry, rs, rys, rss, lat);
    checks++;
    if (ry !== 9'h070 || rys !== 9'h070) begin
      errors++;
      $display("FAIL rsub_cross_chunk: y=%h y_sat=%h required 070 070", ry, rys);
    end
    run_beat(8'h5A, 8'h5A, 2'b01, ry, rs, rys, rss, lat);
    checks++;
    if (ry !== 9'h000 || rys !== 9'h000 || rss !== 1'b0) begin
      errors++;
      $display("FAIL sub_equal: y=%h y_sat=%h sat_sat=%b required 000 000 0", ry, rys, rss);
    end
  endtask

  task automatic test_carry_in;
    logic [8:0] ry, rys;
    logic rs, rss;
    int lat;
    run_beat(8'hFF, 8'hFF, 2'b11, ry, rs, rys, rss, lat);
    checks++;
    if (ry !== 9'h1FF || rs !== 1'b0) begin
      errors++;
      $display("FAIL addc_max: y=%h sat=%b required 1ff 0", ry, rs);
    end
    checks++;
    if (rys !== 9'h1FF || rss !== 1'b1) begin
      errors++;
      $display("FAIL addc_max_sat: y=%h sat=%b required 1ff 1", rys, rss);
    end
    run_beat(8'h0F, 8'h00, 2'b11, ry, rs, rys, rss, lat);
    checks++;
    if (ry !== 9'h010 || rys !== 9'h010 || rss !== 1'b0) begin
      errors++;
      $display("FAIL addc_chunk_ripple: y=%h y_sat=%h sat_sat=%b required 010 010 0", ry, rys, rss);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_q[$];
    logic [8:0] held, e;
    logic       was_stalled;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; was_stalled = 1'b0; held = '0;
    while (got < 6 && cyc < 40) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 7);
      if (sent < 6) begin
        in_valid = 1'b1; a = 8'(sent); b = 8'(10 * sent); op = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: cycle %0d in_ready=%b required 0", cyc, in_ready);
        end
        if (was_stalled) begin
          checks++;
          if (y !== held) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d y=%h required %h", cyc, y, held);
          end
        end
        held = y;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: cycle %0d y=%h required no beat", cyc, y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin
            errors++;
            $display("FAIL stream_order: beat %0d y=%h required %h", got, y, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, a} + {1'b0, b});
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 6 || sent != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: sent=%0d got=%0d left=%0d required 6 6 0", sent, got, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_dup: out_valid=%b y=%h required out_valid 0", out_valid, y);
    end
  endtask

  task automatic test_stage1;
    logic [4:0] exp_q[$];
    logic [4:0] e;
    out_ready4 = 1'b1; op4 = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid4 !== 1'b1 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL stage1_latency: beat %0d out_valid=%b required 1", i - 1, out_valid4);
        end else begin
          e = exp_q.pop_front();
          if (y4 !== e) begin
            errors++;
            $display("FAIL stage1_sum: beat %0d y=%h required %h", i - 1, y4, e);
          end
        end
      end
      in_valid4 = 1'b1;
      if (i == 0) begin
        a4 = 4'hF; b4 = 4'hF;
      end else begin
        a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
      end
      exp_q.push_back({1'b0, a4} + {1'b0, b4});
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    checks++;
    if (out_valid4 !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL stage1_last: out_valid=%b required 1", out_valid4);
    end else begin
      e = exp_q.pop_front();
      if (y4 !== e) begin
        errors++;
        $display("FAIL stage1_last_sum: y=%h required %h", y4, e);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL stage1_drain: out_valid=%b required 0", out_valid4);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; op4 = '0;
    test_reset();
    test_carry_chain();
    test_subtract();
    test_carry_in();
    test_back_to_back();
    test_stage1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
